// File: rtl/weight_fetch_pack.sv
`default_nettype none

`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif

// ============================================================================
// Module      : weight_fetch_pack
// Description : Accepts weight addresses from the address generator, reads
//               the weight SRAM (1-cycle latency), packs PACK_N returned words
//               into one PE-array column vector and buffers the vectors in a
//               first-word fall-through FIFO with a valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_fetch_pack #(
    parameter int ADDR_W     = `ADDR_SIZE,
    parameter int DATA_W     = 8,
    parameter int PACK_N     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     addr_valid,
    input  logic [ADDR_W-1:0]        addr_in,
    input  logic                     addr_last,
    output logic                     addr_ready,
    output logic                     mem_ren,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PACK_N*DATA_W-1:0] out_data,
    output logic                     out_last
);

    localparam int FILL_W = (PACK_N > 1) ? $clog2(PACK_N) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int VEC_W  = PACK_N * DATA_W;

    localparam logic [FILL_W-1:0] c_LAST_LANE = FILL_W'(PACK_N - 1);
    localparam logic [CNT_W-1:0]  c_DEPTH     = CNT_W'(FIFO_DEPTH);

    // Pack state
    logic [FILL_W-1:0] r_fill;
    logic [FILL_W-1:0] w_fill_eff;
    logic              r_inflight;
    logic              r_completes;
    logic              r_lastflag;
    logic [VEC_W-1:0]  r_pack;
    logic [VEC_W-1:0]  w_vec;

    // FIFO state; each entry holds {last, vector}
    logic [VEC_W:0]    r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [VEC_W:0]    w_head;

    logic w_accept;
    logic w_pending;
    logic w_push;
    logic w_pop;

    // A completing read in flight already owns one FIFO slot, so it is counted
    // before admitting a new address; a push can then never hit a full FIFO.
    assign w_pending  = r_inflight & r_completes;
    assign addr_ready = rstn & ((r_count + CNT_W'(w_pending)) < c_DEPTH);
    assign w_accept   = addr_valid & addr_ready;
    assign mem_ren    = w_accept;
    assign mem_addr   = addr_in;

    assign w_push = r_inflight & r_completes;
    assign w_pop  = out_valid & out_ready;

    // Lane the next accepted address will land in, accounting for the read
    // whose data is returning this very cycle.
    always_comb begin
        w_fill_eff = r_fill;
        if (r_inflight) begin
            w_fill_eff = r_completes ? '0 : (r_fill + 1'b1);
        end
    end

    // Pack register with the returning word merged into lane[fill]; higher
    // lanes are still zero because the register clears after every vector.
    always_comb begin
        w_vec = r_pack;
        for (int i = 0; i < PACK_N; i++) begin
            if (r_fill == FILL_W'(i)) begin
                w_vec[i*DATA_W +: DATA_W] = mem_rdata;
            end
        end
    end

    // In-flight tracking and lane packing
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_inflight  <= 1'b0;
            r_completes <= 1'b0;
            r_lastflag  <= 1'b0;
            r_fill      <= '0;
            r_pack      <= '0;
        end else begin
            r_inflight  <= w_accept;
            r_completes <= w_accept & ((w_fill_eff == c_LAST_LANE) | addr_last);
            r_lastflag  <= w_accept & addr_last;
            if (r_inflight) begin
                if (r_completes) begin
                    r_fill <= '0;
                    r_pack <= '0;
                end else begin
                    r_fill <= r_fill + 1'b1;
                    r_pack <= w_vec;
                end
            end
        end
    end

    // FIFO storage; contents need no reset because the count gates the head
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= {r_lastflag, w_vec};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keeps the count
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head    = r_fifo_mem[r_rd_ptr];
    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? w_head[VEC_W-1:0] : '0;
    assign out_last  = out_valid & w_head[VEC_W];

endmodule

`default_nettype wire

// File: tb/tb_weight_fetch_pack.sv
`default_nettype none

// ============================================================================
// Module      : tb_weight_fetch_pack
// Description : Scoreboard bench for weight_fetch_pack; SRAM model mem[a]=a+1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_fetch_pack;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int PACK_N = 4;
    localparam int DEPTH  = 4;
    localparam int VEC_W  = PACK_N * DATA_W;

    logic              clk;
    logic              rstn;
    logic              addr_valid;
    logic [ADDR_W-1:0] addr_in;
    logic              addr_last;
    logic              addr_ready;
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [VEC_W-1:0]  out_data;
    logic              out_last;

    int checks;
    int failures;
    int cyc;
    int n_acc;
    int acc_cyc;
    int last_pop_cyc;
    logic toggle_en;
    logic [VEC_W:0] exp_q[$];

    weight_fetch_pack #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .PACK_N     (PACK_N),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .addr_valid (addr_valid),
        .addr_in    (addr_in),
        .addr_last  (addr_last),
        .addr_ready (addr_ready),
        .mem_ren    (mem_ren),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: one cycle read latency, mem[a] = a + 1
    always @(posedge clk) begin
        mem_rdata <= mem_ren ? DATA_W'(mem_addr + 16'd1) : '0;
    end

    // Monitor: compares every popped head against the scoreboard queue
    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL pop_unexpected: got last=%0b data=%h, required no output", out_last, out_data);
            end else begin
                logic [VEC_W:0] e;
                e = exp_q.pop_front();
                if ({out_last, out_data} !== e) begin
                    failures = failures + 1;
                    $display("FAIL pop_vector: got last=%0b data=%h, required last=%0b data=%h",
                             out_last, out_data, e[VEC_W], e[VEC_W-1:0]);
                end
            end
            if (out_last) last_pop_cyc = cyc;
        end
    end

    // Pseudo-random output backpressure for the integration stream
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        checks = checks + 1;
        if (got !== req) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic push_exp(input logic last, input logic [VEC_W-1:0] data);
        exp_q.push_back({last, data});
    endtask

    // Streams n consecutive addresses from 'first'; last flag on index last_at
    task automatic send(input int first, input int n, input int last_at);
        for (int i = 0; i < n; i++) begin
            logic acc;
            int   guard;
            addr_valid = 1'b1;
            addr_in    = ADDR_W'(first + i);
            addr_last  = (i == last_at);
            acc   = 1'b0;
            guard = 0;
            while (!acc) begin
                @(negedge clk);
                acc = addr_ready;
                if (acc) begin
                    acc_cyc = cyc;
                    n_acc   = n_acc + 1;
                end
                @(posedge clk);
                #1;
                guard++;
                if (!acc && guard > 2000) begin
                    failures = failures + 1;
                    checks   = checks + 1;
                    $display("FAIL send_timeout: address %0d not accepted, required acceptance", first + i);
                    acc = 1'b1;
                end
            end
        end
        addr_valid = 1'b0;
        addr_last  = 1'b0;
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            @(posedge clk);
            guard++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        check({name, "_empty"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        cyc          = 0;
        n_acc        = 0;
        acc_cyc      = 0;
        last_pop_cyc = 0;
        toggle_en    = 1'b0;
        rstn         = 1'b0;
        addr_valid   = 1'b0;
        addr_in      = '0;
        addr_last    = 1'b0;
        out_ready    = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        addr_valid = 1'b1;
        #1;
        check("rst_addr_ready", 64'(addr_ready), 64'd0);
        check("rst_mem_ren", 64'(mem_ren), 64'd0);
        addr_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Scenario 1: two full vectors, last on address 7, latency 2
        push_exp(1'b0, 32'h04030201);
        push_exp(1'b1, 32'h08070605);
        send(0, 8, 7);
        drain("s1");
        check("s1_latency", 64'(last_pop_cyc - acc_cyc), 64'd2);

        // Scenario 2: early close on last, upper lanes zero
        push_exp(1'b0, 32'h04030201);
        push_exp(1'b1, 32'h00000605);
        send(0, 6, 5);
        drain("s2");

        // Scenario 3: backpressure, 16 addresses fill the FIFO then stall
        out_ready = 1'b0;
        for (int v = 0; v < 6; v++) begin
            push_exp(v == 5, {8'(4*v+4), 8'(4*v+3), 8'(4*v+2), 8'(4*v+1)});
        end
        n_acc = 0;
        fork
            send(0, 24, 23);
            begin
                repeat (40) @(posedge clk);
                #2;
                check("bp_accepted", 64'(n_acc), 64'd16);
                check("bp_addr_ready", 64'(addr_ready), 64'd0);
                check("bp_out_valid", 64'(out_valid), 64'd1);
                check("bp_head", 64'(out_data), 64'h04030201);
                out_ready = 1'b1;
            end
        join
        drain("bp");

        // Scenario 4: 3 buffered plus completing read, pop and push together
        out_ready = 1'b0;
        for (int v = 0; v < 4; v++) begin
            push_exp(v == 3, {8'(4*v+4), 8'(4*v+3), 8'(4*v+2), 8'(4*v+1)});
        end
        send(0, 16, 15);
        check("full_reserved_ready", 64'(addr_ready), 64'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("full_after_swap_valid", 64'(out_valid), 64'd1);
        check("full_after_swap_head", 64'(out_data), 64'h08070605);
        out_ready = 1'b1;
        drain("full");

        // Scenario 5: generator stream, 2x2 kernel, 3 channels, 10 kernels
        for (int v = 0; v < 30; v++) begin
            push_exp(v == 29, {8'(4*v+4), 8'(4*v+3), 8'(4*v+2), 8'(4*v+1)});
        end
        toggle_en = 1'b1;
        send(0, 120, 119);
        toggle_en = 1'b0;
        #1;
        out_ready = 1'b1;
        drain("gen");

        // Scenario 6: asynchronous reset with 2 vectors buffered and a read in flight
        out_ready = 1'b0;
        send(0, 9, -1);
        check("mid_buffered", 64'(out_valid), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_addr_ready", 64'(addr_ready), 64'd0);
        check("mid_rst_out_data", 64'(out_data), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn      = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        push_exp(1'b0, 32'h04030201);
        push_exp(1'b1, 32'h08070605);
        send(0, 8, 7);
        drain("s1_again");
        check("s1_again_latency", 64'(last_pop_cyc - acc_cyc), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
